// File: rtl/xilinx_bram_pkg.sv
// xilinx_bram_pkg: shared types and address helpers for the banked simple-dual-port BRAM
package xilinx_bram_pkg;

    typedef enum logic {RdLat1, RdLat2} rd_lat_e;

    // Never returns 0 so a single-bank build still has a one-bit bank select.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned bank_of(input int unsigned addr, input int unsigned banks);
        return addr % banks;
    endfunction

    function automatic int unsigned row_of(input int unsigned addr, input int unsigned banks);
        return addr / banks;
    endfunction

endpackage

// File: rtl/xilinx_sdp_bram_bank.sv
// xilinx_sdp_bram_bank: one simple-dual-port byte-write BRAM bank with read enable, no output register
module xilinx_sdp_bram_bank #(
  parameter int BYTE_WIDTH = 8,
  parameter int NUM_BYTES  = 8,
  parameter int DEPTH      = 512,
  parameter int ROW_W      = 9,
  parameter int NUM_BANKS  = 2,
  parameter int BANK       = 0,
  parameter     INIT_FILE  = ""
) (
  input  logic                            clk_i,
  input  logic                            i_we,
  input  logic [ROW_W-1:0]                i_waddr,
  input  logic [NUM_BYTES*BYTE_WIDTH-1:0] i_wdata,
  input  logic [NUM_BYTES-1:0]            i_wbe,
  input  logic                            i_re,
  input  logic [ROW_W-1:0]                i_raddr,
  output logic [NUM_BYTES*BYTE_WIDTH-1:0] o_rdata
);
  localparam int W = NUM_BYTES * BYTE_WIDTH;
  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;
  initial begin
    for (int r = 0; r < DEPTH; r++) r_mem[r] = '0;
  end
  always_ff @(posedge clk_i) begin
    if (i_we)
      for (int i = 0; i < NUM_BYTES; i++)
        if (i_wbe[i]) r_mem[i_waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= i_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
    if (i_re) r_rdata <= r_mem[i_raddr];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/xilinx_sdp_bram_byte_en_banked.sv
// xilinx_sdp_bram_byte_en_banked: banked SDP byte-write BRAM with req/valid reads, 1 or 2 cycle latency
// Optional macro XILINX_BRAM_COLLISION_FWD_EN: same-address collisions return written bytes (write-first per byte).
module xilinx_sdp_bram_byte_en_banked
    import xilinx_bram_pkg::*;
#(
    parameter int BYTE_WIDTH   = 8,
    parameter int DATA_WIDTH   = 64,
    parameter int RAM_DEPTH    = 1024,
    parameter int NUM_BANKS    = 2,
    parameter int READ_LATENCY = 2,
    parameter     INIT_FILE    = "",
    localparam int NumBytes    = DATA_WIDTH / BYTE_WIDTH,
    localparam int AddrW       = $clog2(RAM_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wreq_i,
    input  logic [AddrW-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [NumBytes-1:0]   wbe_i,
    input  logic                  rreq_i,
    input  logic [AddrW-1:0]      raddr_i,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rerr_o
);

    localparam int      BankW     = clog2_min1(NUM_BANKS);
    localparam int      BankDepth = (RAM_DEPTH + NUM_BANKS - 1) / NUM_BANKS;
    localparam int      RowW      = clog2_min1(BankDepth);
    localparam rd_lat_e RdLat     = (READ_LATENCY == 1) ? RdLat1 : RdLat2;

    logic [BankW-1:0]      w_wbank, w_rbank;
    logic [RowW-1:0]       w_wrow, w_rrow;
    logic                  w_win, w_rin;
    logic [NUM_BANKS-1:0]  w_we, w_re;
    logic [DATA_WIDTH-1:0] w_bank_rdata [NUM_BANKS];
    logic [DATA_WIDTH-1:0] w_rdata1, w_rout;
    logic                  r_v1, r_err1;
    logic [BankW-1:0]      r_bank1;

    assign w_win   = 32'(waddr_i) < RAM_DEPTH;
    assign w_rin   = 32'(raddr_i) < RAM_DEPTH;
    assign w_wbank = BankW'(bank_of(32'(waddr_i), NUM_BANKS));
    assign w_rbank = BankW'(bank_of(32'(raddr_i), NUM_BANKS));
    assign w_wrow  = RowW'(row_of(32'(waddr_i), NUM_BANKS));
    assign w_rrow  = RowW'(row_of(32'(raddr_i), NUM_BANKS));

    // Only the addressed bank sees an enable, keeping idle banks quiet.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_we[b] = wreq_i & w_win & (w_wbank == BankW'(b));
            w_re[b] = rreq_i & ~rst_i & w_rin & (w_rbank == BankW'(b));
        end
    end

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        xilinx_sdp_bram_bank #(
            .BYTE_WIDTH(BYTE_WIDTH),
            .NUM_BYTES (NumBytes),
            .DEPTH     (BankDepth),
            .ROW_W     (RowW),
            .NUM_BANKS (NUM_BANKS),
            .BANK      (k),
            .INIT_FILE (INIT_FILE)
        ) u_bank (
            .clk_i  (clk_i),
            .i_we   (w_we[k]),
            .i_waddr(w_wrow),
            .i_wdata(wdata_i),
            .i_wbe  (wbe_i),
            .i_re   (w_re[k]),
            .i_raddr(w_rrow),
            .o_rdata(w_bank_rdata[k])
        );
    end

    // Bank select and error flag only move on a request so the output holds between reads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_v1    <= 1'b0;
            r_err1  <= 1'b1;
            r_bank1 <= '0;
        end else begin
            r_v1 <= rreq_i;
            if (rreq_i) begin
                r_err1  <= ~w_rin;
                r_bank1 <= w_rbank;
            end
        end
    end

`ifdef XILINX_BRAM_COLLISION_FWD_EN
    logic [NumBytes-1:0]   r_fmask;
    logic [DATA_WIDTH-1:0] r_fdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fmask <= '0;
        end else if (rreq_i) begin
            r_fmask <= (wreq_i && w_rin && waddr_i == raddr_i) ? wbe_i : '0;
            r_fdata <= wdata_i;
        end
    end

    always_comb begin
        w_rdata1 = w_bank_rdata[r_bank1];
        for (int i = 0; i < NumBytes; i++)
            if (r_fmask[i]) w_rdata1[i*BYTE_WIDTH +: BYTE_WIDTH] = r_fdata[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
`else
    assign w_rdata1 = w_bank_rdata[r_bank1];
`endif

    assign w_rout = r_err1 ? '0 : w_rdata1;

    if (RdLat == RdLat2) begin : g_oreg
        logic                  r_rvalid, r_rerr;
        logic [DATA_WIDTH-1:0] r_rdata;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_rvalid <= 1'b0;
                r_rerr   <= 1'b0;
                r_rdata  <= '0;
            end else begin
                r_rvalid <= r_v1;
                r_rerr   <= r_v1 & r_err1;
                if (r_v1) r_rdata <= w_rout;
            end
        end

        assign rvalid_o = r_rvalid;
        assign rerr_o   = r_rerr;
        assign rdata_o  = r_rdata;
    end else begin : g_noreg
        assign rvalid_o = r_v1;
        assign rerr_o   = r_v1 & r_err1;
        assign rdata_o  = w_rout;
    end

endmodule

// File: tb/tb_xilinx_sdp_bram_byte_en_banked.sv
// tb_xilinx_sdp_bram_byte_en_banked: directed bench with a flat-memory reference model and literal pins
module tb_xilinx_sdp_bram_byte_en_banked;

    localparam int Depth = 1000;
    localparam int Lat   = 2;

    logic        clk_i = 1'b0;
    logic        rst_i, wreq_i, rreq_i;
    logic [9:0]  waddr_i, raddr_i;
    logic [63:0] wdata_i;
    logic [7:0]  wbe_i;
    logic        rvalid_o, rerr_o;
    logic [63:0] rdata_o;

    always #5 clk_i = ~clk_i;

    xilinx_sdp_bram_byte_en_banked #(
        .BYTE_WIDTH  (8),
        .DATA_WIDTH  (64),
        .RAM_DEPTH   (Depth),
        .NUM_BANKS   (2),
        .READ_LATENCY(Lat),
        .INIT_FILE   ("")
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wreq_i  (wreq_i),
        .waddr_i (waddr_i),
        .wdata_i (wdata_i),
        .wbe_i   (wbe_i),
        .rreq_i  (rreq_i),
        .raddr_i (raddr_i),
        .rvalid_o(rvalid_o),
        .rdata_o (rdata_o),
        .rerr_o  (rerr_o)
    );

    typedef struct { int due; logic [63:0] d; logic e; } rsp_t;
    typedef struct { int cyc; logic v; logic [63:0] d; logic e; int tag; } lit_t;

    rsp_t        q[$];
    lit_t        lit[$];
    logic [63:0] mem [Depth] = '{default: '0};
    int          pc = 0, li = 0, tests = 0, fails = 0;
    bit          started = 0, done = 0;
    logic        exp_v = 1'b0, exp_e = 1'b0;
    logic [63:0] exp_d = 64'h0;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] be);
        logic [63:0] m = old;
        for (int i = 0; i < 8; i++) if (be[i]) m[i*8 +: 8] = nw[i*8 +: 8];
        return m;
    endfunction

    // Reference: a response is due Lat-1 posedges after the posedge that accepted the request.
    always @(posedge clk_i) begin
        rsp_t r;
        pc = pc + 1;
        if (rst_i) begin
            q.delete();
            started = 1;
        end else if (rreq_i) begin
            r.due = pc + Lat - 1;
            r.e   = 32'(raddr_i) >= Depth;
            r.d   = r.e ? 64'h0 : mem[raddr_i];
`ifdef XILINX_BRAM_COLLISION_FWD_EN
            if (!r.e && wreq_i && waddr_i == raddr_i) r.d = merge(r.d, wdata_i, wbe_i);
`endif
            q.push_back(r);
        end
        if (rst_i) begin
            exp_v = 1'b0;
            exp_e = 1'b0;
            exp_d = 64'h0;
        end else if (q.size() > 0 && q[0].due == pc) begin
            exp_v = 1'b1;
            exp_d = q[0].d;
            exp_e = q[0].e;
            void'(q.pop_front());
        end else begin
            exp_v = 1'b0;
            exp_e = 1'b0;
        end
        if (wreq_i && 32'(waddr_i) < Depth) mem[waddr_i] = merge(mem[waddr_i], wdata_i, wbe_i);
    end

    always @(negedge clk_i) begin
        if (started) begin
            tests++;
            if (rvalid_o !== exp_v || rerr_o !== exp_e || rdata_o !== exp_d) begin
                fails++;
                $display("FAIL model cyc=%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                         pc, rvalid_o, rerr_o, rdata_o, exp_v, exp_e, exp_d);
            end
            if (li < lit.size() && lit[li].cyc == pc) begin
                tests++;
                if (rvalid_o !== lit[li].v || rerr_o !== lit[li].e || rdata_o !== lit[li].d) begin
                    fails++;
                    $display("FAIL lit%0d cyc=%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                             lit[li].tag, pc, rvalid_o, rerr_o, rdata_o, lit[li].v, lit[li].e, lit[li].d);
                end
                li++;
            end
        end
        if (done) begin
            tests++;
            if (li != lit.size()) begin
                fails++;
                $display("FAIL lit_pending: got %0d unchecked, want 0", lit.size() - li);
            end
        end
    end

    task automatic step(input logic w, input logic [9:0] wa, input logic [63:0] wd, input logic [7:0] be,
                        input logic r, input logic [9:0] ra);
        wreq_i  = w;
        waddr_i = wa;
        wdata_i = wd;
        wbe_i   = be;
        rreq_i  = r;
        raddr_i = ra;
        @(posedge clk_i);
        #1;
        wreq_i = 1'b0;
        rreq_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 10'd0, 64'h0, 8'h0, 1'b0, 10'd0);
    endtask

    task automatic wr(input logic [9:0] a, input logic [63:0] d, input logic [7:0] be);
        step(1'b1, a, d, be, 1'b0, 10'd0);
    endtask

    // Issues a read and pins the response Lat cycles later to literal values.
    task automatic rd(input logic [9:0] a, input logic [63:0] d, input logic e, input int tag);
        step(1'b0, 10'd0, 64'h0, 8'h0, 1'b1, a);
        lit.push_back('{pc + Lat - 1, 1'b1, d, e, tag});
    endtask

    initial begin
        rst_i   = 1'b1;
        wreq_i  = 1'b0;
        rreq_i  = 1'b0;
        waddr_i = 10'd0;
        raddr_i = 10'd0;
        wdata_i = 64'h0;
        wbe_i   = 8'h0;
        repeat (3) @(posedge clk_i);
        #1;
        lit.push_back('{pc, 1'b0, 64'h0, 1'b0, 0});
        rst_i = 1'b0;
        idle(1);

        wr(10'd5, 64'h1122334455667788, 8'hFF);
        rd(10'd5, 64'h1122334455667788, 1'b0, 1);
        idle(3);
        wr(10'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        rd(10'd5, 64'h11223344AAAAAAAA, 1'b0, 2);
        idle(3);

        wr(10'd6, 64'hA, 8'hFF);
        wr(10'd7, 64'hB, 8'hFF);
        rd(10'd6, 64'hA, 1'b0, 3);
        rd(10'd7, 64'hB, 1'b0, 4);
        rd(10'd6, 64'hA, 1'b0, 5);
        idle(3);

        step(1'b1, 10'd8, 64'h88, 8'hFF, 1'b1, 10'd6);
        lit.push_back('{pc + Lat - 1, 1'b1, 64'hA, 1'b0, 6});
        idle(3);

        wr(10'd5, 64'h0, 8'hFF);
        step(1'b1, 10'd5, 64'hFFFFFFFFFFFFFFFF, 8'h01, 1'b1, 10'd5);
`ifdef XILINX_BRAM_COLLISION_FWD_EN
        lit.push_back('{pc + Lat - 1, 1'b1, 64'h00000000000000FF, 1'b0, 7});
`else
        lit.push_back('{pc + Lat - 1, 1'b1, 64'h0, 1'b0, 7});
`endif
        rd(10'd5, 64'h00000000000000FF, 1'b0, 8);
        idle(3);

        wr(10'd999, 64'h999, 8'hFF);
        wr(10'd1000, 64'hDEAD, 8'hFF);
        rd(10'd1000, 64'h0, 1'b1, 9);
        rd(10'd999, 64'h999, 1'b0, 10);
        rd(10'd1023, 64'h0, 1'b1, 11);
        rd(10'd8, 64'h88, 1'b0, 12);
        idle(4);

        step(1'b0, 10'd0, 64'h0, 8'h0, 1'b1, 10'd7);
        lit.push_back('{pc + Lat - 1, 1'b0, 64'h0, 1'b0, 13});
        rst_i = 1'b1;
        idle(1);
        rst_i = 1'b0;
        idle(3);
        rd(10'd6, 64'hA, 1'b0, 14);
        rd(10'd7, 64'hB, 1'b0, 15);
        idle(4);

        done = 1;
        @(negedge clk_i);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
